// File: rtl/rr_arb_4_idx.sv
// Four-requester round-robin arbiter with a registered 2-bit grant index,
// a hold watchdog and a one-cycle idle gap between successive owners.
module rr_arb_4_idx #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold count value before the watchdog revokes the grant.
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [7:0] hcnt_reg, hcnt_next;
    logic       gnt_valid_reg, gnt_valid_next;
    logic [1:0] gnt_idx_reg, gnt_idx_next;
    logic       timeout_reg, timeout_next;

    logic [3:0] rot_req;
    logic [1:0] win_off;
    logic [1:0] winner;

    // Requests rotated so that position 0 is the current priority holder.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    // Lowest set position in the rotated vector is the winner's offset from ptr.
    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 2'(i);
            end
        end
    end

    assign winner = ptr_reg + win_off;

    // Next-state and output logic for the IDLE/GRANT controller.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        hcnt_next      = hcnt_reg;
        gnt_valid_next = gnt_valid_reg;
        gnt_idx_next   = gnt_idx_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_idx_next   = winner;
                    gnt_valid_next = 1'b1;
                    hcnt_next      = 8'd0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (done || (hcnt_reg == HOLD_LAST)) begin
                    // Release; a simultaneous done makes it a normal release.
                    gnt_valid_next = 1'b0;
                    ptr_next       = gnt_idx_reg + 2'd1;
                    state_next     = IDLE;
                    timeout_next   = ~done;
                end else begin
                    hcnt_next = hcnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd0;
            hcnt_reg      <= 8'd0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= 2'd0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            hcnt_reg      <= hcnt_next;
            gnt_valid_reg <= gnt_valid_next;
            gnt_idx_reg   <= gnt_idx_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign gnt_valid = gnt_valid_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arb_4_idx.sv
// Scoreboard bench for rr_arb_4_idx: the driver updates a behavioural model
// per edge and queues the expected outputs; a monitor compares after each edge.
module tb_rr_arb_4_idx;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    rr_arb_4_idx #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model state: owner, priority start, edges held so far.
    bit m_valid = 0;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 0;

    function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Apply the arbitration rules for one rising edge.
    function automatic void model_edge(logic [3:0] r, logic d, logic rs);
        int w;
        if (rs) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_valid) begin
            m_to = 0;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) begin
                m_idx = w; m_valid = 1; m_held = 0;
            end
        end else begin
            m_to = 0;
            if (d || m_held == TO - 1) begin
                m_to    = !d;
                m_valid = 0;
                m_ptr   = (m_idx + 1) % 4;
            end else begin
                m_held++;
            end
        end
    endfunction

    task automatic step(input logic [3:0] r, input logic d, input logic rs);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        model_edge(r, d, rs);
        e.v   = m_valid;
        e.idx = 2'(m_idx);
        e.to  = m_to;
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs shortly after each edge.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gnt_valid", {3'b0, gnt_valid}, {3'b0, e.v});
                check("gnt_idx",   {2'b0, gnt_idx},   {2'b0, e.idx});
                check("timeout",   {3'b0, timeout},   {3'b0, e.to});
                if (gnt_valid === 1'b1 && prev_v !== 1'b1) begin
                    $display("grant idx=%0d t=%0t", gnt_idx, $time);
                    grant_log.push_back(int'(gnt_idx));
                end
                if (timeout === 1'b1) $display("watchdog release t=%0t", $time);
                prev_v = gnt_valid;
            end
        end
    end

    initial begin
        int rot_exp[5];
        rot_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = 4'b0; done = 1'b0;

        // Reset state.
        step(4'h0, 1'b0, 1'b1);
        step(4'h0, 1'b1, 1'b1);
        grant_log.delete();

        // All requesters held, done in the first grant cycle: rotation 0,1,2,3,0.
        step(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(4'hF, m_valid, 1'b0);
        step(4'h0, m_valid, 1'b0);
        step(4'h0, m_valid, 1'b0);
        check("rotation_count", {3'b0, grant_log.size() >= 5}, 4'd1);
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > i) check("rotation_idx", 4'(grant_log[i]), 4'(rot_exp[i]));
        end

        // Wrap search: grant to 1, release, then req=0011 must go to 0.
        step(4'h0, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Watchdog: grant to 3, no done, then regrant to 3 via ptr=0.
        step(4'h0, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // done on the expiry edge: normal release, no timeout pulse.
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Reset mid-grant, then a grant to 2 on the first free edge.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // One-cycle request pulse; grant held through req drop until done.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Randomized traffic with occasional resets and done in IDLE.
        for (int i = 0; i < 500; i++) begin
            step(4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end

        step(4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", 4'(q.size()), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
